// File: rtl/hv_memory_server_pkg.sv
// Shared constants and types for the per-modality HV memory server.
// Bank and state encodings are kept here so the server and the encoder agree on them.
package hv_memory_server_pkg;

    localparam int HV_DIMENSION            = 2000;
    localparam int FIRST_MODALITY_CHANNELS = 32;
    localparam int LOAD_WIDTH              = 32;

    typedef enum logic [1:0] {
        BANK_IM  = 2'd0,
        BANK_NEG = 2'd1,
        BANK_POS = 2'd2
    } bank_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SERVE = 2'd2
    } srv_state_e;

    // Wide enough to hold n itself, so an address one past the last row can be presented.
    function automatic int addr_width(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/hv_memory_server_if.sv
// Load and read-port bundle between the spatial encoder (master) and one modality's memory server (slave).
interface hv_memory_server_if #(
    parameter int HV_DIM = hv_memory_server_pkg::HV_DIMENSION,
    parameter int LOAD_W = hv_memory_server_pkg::LOAD_WIDTH,
    parameter int ADDR_W = hv_memory_server_pkg::addr_width(hv_memory_server_pkg::FIRST_MODALITY_CHANNELS)
);
    // Load beats transfer on a rising edge where LoadValid_SI && LoadReady_SO; the master holds
    // LoadData_DI stable until then. Reads: the master holds Req_SI and Addr_DI until Valid_SO is high.
    logic                           LoadValid_SI;
    logic                           LoadReady_SO;
    logic [0:LOAD_W-1]              LoadData_DI;
    logic                           LoadDone_SO;
    logic                           Req_SI;
    logic [ADDR_W-1:0]              Addr_DI;
    logic                           Ready_SO;
    logic                           Valid_SO;
    logic [0:HV_DIM-1]              ImOut_DO;
    logic [0:HV_DIM-1]              ProjNeg_DO;
    logic [0:HV_DIM-1]              ProjPos_DO;
    hv_memory_server_pkg::srv_state_e State_DO;

    modport master (
        output LoadValid_SI, LoadData_DI, Req_SI, Addr_DI,
        input  LoadReady_SO, LoadDone_SO, Ready_SO, Valid_SO,
        input  ImOut_DO, ProjNeg_DO, ProjPos_DO, State_DO
    );

    modport slave (
        input  LoadValid_SI, LoadData_DI, Req_SI, Addr_DI,
        output LoadReady_SO, LoadDone_SO, Ready_SO, Valid_SO,
        output ImOut_DO, ProjNeg_DO, ProjPos_DO, State_DO
    );

endinterface

// File: rtl/hv_memory_server_row_assembler.sv
// Collects BEATS load beats into one HV row; the completed row is presented combinationally
// in the cycle its final beat is accepted, so it can be written without an extra stage.
module hv_row_assembler #(
    parameter int HV_DIM = 2000,
    parameter int LOAD_W = 32,
    parameter int BEATS  = 63
) (
    input  logic              Clk_CI,
    input  logic              Reset_RBI,
    input  logic              clear,
    input  logic              beat_valid,
    input  logic [0:LOAD_W-1] beat_data,
    output logic [0:HV_DIM-1] row,
    output logic              row_done
);
    localparam int SR_W  = BEATS * LOAD_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    logic [CNT_W-1:0]         beat_q;
    logic [CNT_W-1:0]         beat_cur;
    logic [0:SR_W-LOAD_W-1]   hist_q;
    logic [0:SR_W-1]          shifted;

    // A clear in the same cycle as a beat makes that beat beat 0 of a fresh row.
    assign beat_cur = clear ? '0 : beat_q;
    assign shifted  = {hist_q, beat_data};
    assign row      = shifted[0:HV_DIM-1];
    assign row_done = beat_valid && (beat_cur == LAST_BEAT);

    always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
        if (!Reset_RBI) begin
            beat_q <= '0;
        end else if (beat_valid) begin
            beat_q <= row_done ? '0 : beat_cur + 1'b1;
        end else begin
            beat_q <= beat_cur;
        end
    end

    always_ff @(posedge Clk_CI) begin
        if (beat_valid) begin
            hist_q <= shifted[LOAD_W:SR_W-1];
        end
    end

endmodule

// File: rtl/hv_memory_server.sv
// One modality's IM / PROJ_NEG / PROJ_POS store: streamed fill, then a registered
// three-row read port whose valid tracks the address currently presented.
module hv_memory_server
    import hv_memory_server_pkg::*;
#(
    parameter int HV_DIM   = HV_DIMENSION,
    parameter int CHANNELS = FIRST_MODALITY_CHANNELS,
    parameter int LOAD_W   = LOAD_WIDTH,
    parameter int ADDR_W   = addr_width(CHANNELS)
) (
    input logic               Clk_CI,
    input logic               Reset_RBI,
    hv_memory_server_if.slave mem_if
);
    localparam int BEATS = ceil_div(HV_DIM, LOAD_W);
    localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(CHANNELS - 1);

    srv_state_e        state_q, state_d;
    bank_e             bank_q;
    logic [IDX_W-1:0]  row_q;
    logic              load_ready, load_acc, restart, row_done, load_done;
    logic [0:HV_DIM-1] row_data;
    logic [ADDR_W-1:0] out_addr_q;
    logic              dvld_q;
    logic [0:HV_DIM-1] im_q, neg_q, pos_q;
    logic [IDX_W-1:0]  rd_idx;
    logic              in_range;

    logic [0:HV_DIM-1] im_mem  [0:CHANNELS-1];
    logic [0:HV_DIM-1] neg_mem [0:CHANNELS-1];
    logic [0:HV_DIM-1] pos_mem [0:CHANNELS-1];

    // While serving, an active read request takes priority and stalls the load port.
    assign load_ready = (state_q != ST_SERVE) || !mem_if.Req_SI;
    assign load_acc   = mem_if.LoadValid_SI && load_ready;
    assign restart    = load_acc && (state_q == ST_SERVE);
    assign load_done  = row_done && (bank_q == BANK_POS) && (row_q == LAST_ROW);

    hv_row_assembler #(
        .HV_DIM (HV_DIM),
        .LOAD_W (LOAD_W),
        .BEATS  (BEATS)
    ) u_row_assembler (
        .Clk_CI     (Clk_CI),
        .Reset_RBI  (Reset_RBI),
        .clear      (restart),
        .beat_valid (load_acc),
        .beat_data  (mem_if.LoadData_DI),
        .row        (row_data),
        .row_done   (row_done)
    );

    always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
        if (!Reset_RBI) state_q <= ST_EMPTY;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (load_acc)  state_d = ST_LOAD;
            ST_LOAD:  if (load_done) state_d = ST_SERVE;
            ST_SERVE: if (load_acc)  state_d = ST_LOAD;
            default:                 state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
        if (!Reset_RBI) begin
            row_q  <= '0;
            bank_q <= BANK_IM;
        end else if (restart) begin
            row_q  <= '0;
            bank_q <= BANK_IM;
        end else if (row_done) begin
            if (row_q == LAST_ROW) begin
                row_q <= '0;
                case (bank_q)
                    BANK_IM:  bank_q <= BANK_NEG;
                    BANK_NEG: bank_q <= BANK_POS;
                    default:  bank_q <= BANK_IM;
                endcase
            end else begin
                row_q <= row_q + 1'b1;
            end
        end
    end

    // Storage is left unreset so the arrays can be replaced by SRAM macros.
    always_ff @(posedge Clk_CI) begin
        if (row_done) begin
            case (bank_q)
                BANK_IM:  im_mem[row_q]  <= row_data;
                BANK_NEG: neg_mem[row_q] <= row_data;
                default:  pos_mem[row_q] <= row_data;
            endcase
        end
    end

    assign rd_idx   = mem_if.Addr_DI[IDX_W-1:0];
    assign in_range = int'(mem_if.Addr_DI) < CHANNELS;

    // Out-of-range addresses return zero rows but still raise valid, so the encoder never stalls.
    always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
        if (!Reset_RBI) begin
            out_addr_q <= '0;
            dvld_q     <= 1'b0;
            im_q       <= '0;
            neg_q      <= '0;
            pos_q      <= '0;
        end else if ((state_q == ST_SERVE) && mem_if.Req_SI) begin
            out_addr_q <= mem_if.Addr_DI;
            dvld_q     <= 1'b1;
            im_q       <= in_range ? im_mem[rd_idx]  : '0;
            neg_q      <= in_range ? neg_mem[rd_idx] : '0;
            pos_q      <= in_range ? pos_mem[rd_idx] : '0;
        end else begin
            dvld_q     <= 1'b0;
        end
    end

    assign mem_if.LoadReady_SO = load_ready;
    assign mem_if.LoadDone_SO  = load_done;
    assign mem_if.Ready_SO     = (state_q == ST_SERVE);
    assign mem_if.Valid_SO     = (state_q == ST_SERVE) && dvld_q && mem_if.Req_SI
                                 && (out_addr_q == mem_if.Addr_DI);
    assign mem_if.ImOut_DO     = im_q;
    assign mem_if.ProjNeg_DO   = neg_q;
    assign mem_if.ProjPos_DO   = pos_q;
    assign mem_if.State_DO     = state_q;

endmodule

// File: tb/tb_hv_memory_server.sv
// Directed bench for hv_memory_server: reads push expected rows into a queue that a
// negedge monitor pops and compares whenever Valid_SO is presented.
module tb_hv_memory_server;
    import hv_memory_server_pkg::*;

    localparam int HV_DIM      = 2000;
    localparam int CHANNELS    = 32;
    localparam int LOAD_W      = 32;
    localparam int ADDR_W      = 6;
    localparam int BEATS       = 63;
    localparam int TOTAL_BEATS = 3 * CHANNELS * BEATS;
    localparam int W           = ADDR_W + 3 * HV_DIM;

    // ---------------- clock / reset ----------------
    logic Clk_CI    = 1'b0;
    logic Reset_RBI = 1'b0;
    always #5 Clk_CI = ~Clk_CI;

    hv_memory_server_if #(.HV_DIM(HV_DIM), .LOAD_W(LOAD_W), .ADDR_W(ADDR_W)) mem_if ();

    hv_memory_server #(
        .HV_DIM   (HV_DIM),
        .CHANNELS (CHANNELS),
        .LOAD_W   (LOAD_W),
        .ADDR_W   (ADDR_W)
    ) dut (
        .Clk_CI    (Clk_CI),
        .Reset_RBI (Reset_RBI),
        .mem_if    (mem_if)
    );

    int errors = 0;
    int checks = 0;
    int done_cnt, done_beat, nrdy_cnt;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_e;
    logic         mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic cmp_row(input string name, input int a, input logic [0:HV_DIM-1] got,
                           input logic [0:HV_DIM-1] exp);
        int first;
        first = 0;
        checks++;
        if (got !== exp) begin
            errors++;
            for (int i = HV_DIM - 1; i >= 0; i--) if (got[i] !== exp[i]) first = i;
            $display("FAIL %s addr %0d: first bad bit %0d got %b expected %b",
                     name, a, first, got[first], exp[first]);
        end
    endtask

    // Row r of bank b, load generation gen; the last beat of IM row 5 is all ones.
    function automatic logic [0:LOAD_W-1] beat_word(input int gen, input int b, input int r, input int k);
        logic [0:LOAD_W-1] w;
        if (b == 0 && r == 5 && k == BEATS - 1) w = '1;
        else w = {4'(10 + gen), 4'(b), 8'(r), 8'(k), 8'h5C};
        return w;
    endfunction

    function automatic logic [0:HV_DIM-1] exp_row(input int gen, input int b, input int r);
        logic [0:HV_DIM-1] row;
        logic [0:LOAD_W-1] w;
        row = '0;
        for (int k = 0; k < BEATS; k++) begin
            w = beat_word(gen, b, r, k);
            for (int i = 0; i < LOAD_W; i++)
                if (k * LOAD_W + i < HV_DIM) row[k * LOAD_W + i] = w[i];
        end
        return row;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic stream(input int gen, input int first, input int count);
        int b, r, k;
        for (int n = first; n < first + count; n++) begin
            b = n / (CHANNELS * BEATS);
            r = (n / BEATS) % CHANNELS;
            k = n % BEATS;
            @(posedge Clk_CI); #1;
            mem_if.LoadValid_SI = 1'b1;
            mem_if.LoadData_DI  = beat_word(gen, b, r, k);
            @(negedge Clk_CI);
            if (!mem_if.LoadReady_SO) nrdy_cnt++;
            if (mem_if.LoadDone_SO) begin
                done_cnt++;
                done_beat = n + 1;
            end
        end
        @(posedge Clk_CI); #1;
        mem_if.LoadValid_SI = 1'b0;
    endtask

    task automatic full_load(input int gen, input string tag);
        done_cnt = 0; done_beat = 0; nrdy_cnt = 0;
        stream(gen, 0, TOTAL_BEATS);
        check({tag, "_done_count"}, 64'(done_cnt), 64'd1);
        check({tag, "_done_beat"}, 64'(done_beat), 64'(TOTAL_BEATS));
        check({tag, "_ready_stalls"}, 64'(nrdy_cnt), 64'd0);
        @(negedge Clk_CI);
        check({tag, "_ready_after"}, 64'(mem_if.Ready_SO), 64'd1);
        check({tag, "_done_clears"}, 64'(mem_if.LoadDone_SO), 64'd0);
    endtask

    task automatic do_read(input int gen, input logic [ADDR_W-1:0] a);
        int cyc;
        logic [0:HV_DIM-1] ei, en, ep;
        cyc = 0;
        ei = '0; en = '0; ep = '0;
        if (int'(a) < CHANNELS) begin
            ei = exp_row(gen, 0, int'(a));
            en = exp_row(gen, 1, int'(a));
            ep = exp_row(gen, 2, int'(a));
        end
        @(posedge Clk_CI); #1;
        mem_if.Req_SI  = 1'b1;
        mem_if.Addr_DI = a;
        mon_en = 1'b1;
        exp_q.push_back({a, ei, en, ep});
        do begin
            @(negedge Clk_CI);
            cyc++;
        end while (!mem_if.Valid_SO && cyc < 10);
        check("rd_latency", 64'(cyc), 64'd2);
        if (!mem_if.Valid_SO && exp_q.size() > 0) void'(exp_q.pop_back());
        @(posedge Clk_CI); #1;
        mon_en = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_load_ready"}, 64'(mem_if.LoadReady_SO), 64'd1);
        check({tag, "_load_done"}, 64'(mem_if.LoadDone_SO), 64'd0);
        check({tag, "_ready"}, 64'(mem_if.Ready_SO), 64'd0);
        check({tag, "_valid"}, 64'(mem_if.Valid_SO), 64'd0);
        check({tag, "_state"}, 64'(mem_if.State_DO), 64'(ST_EMPTY));
        check({tag, "_rows_zero"}, 64'(|{mem_if.ImOut_DO, mem_if.ProjNeg_DO, mem_if.ProjPos_DO}), 64'd0);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge Clk_CI) begin
        if (mon_en && mem_if.Valid_SO) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: addr %0d valid 1 expected no pending read", mem_if.Addr_DI);
            end else begin
                mon_e = exp_q.pop_front();
                cmp_row("im_row", int'(mon_e[W-1 -: ADDR_W]), mem_if.ImOut_DO, mon_e[3*HV_DIM-1 -: HV_DIM]);
                cmp_row("neg_row", int'(mon_e[W-1 -: ADDR_W]), mem_if.ProjNeg_DO, mon_e[2*HV_DIM-1 -: HV_DIM]);
                cmp_row("pos_row", int'(mon_e[W-1 -: ADDR_W]), mem_if.ProjPos_DO, mon_e[HV_DIM-1 -: HV_DIM]);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time expired before completion");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        mem_if.LoadValid_SI = 1'b0;
        mem_if.LoadData_DI  = '0;
        mem_if.Req_SI       = 1'b0;
        mem_if.Addr_DI      = '0;
        repeat (3) @(posedge Clk_CI);
        @(negedge Clk_CI);
        check_reset("rst");
        @(posedge Clk_CI); #1;
        Reset_RBI = 1'b1;

        full_load(0, "load0");
        check("serve_state", 64'(mem_if.State_DO), 64'(ST_SERVE));

        for (int a = 0; a < CHANNELS; a++) do_read(0, ADDR_W'(a));

        do_read(0, 6'd5);
        @(negedge Clk_CI);
        check("partial_beat_ones", 64'(mem_if.ImOut_DO[1984:1999]), 64'hFFFF);

        do_read(0, 6'd32);
        do_read(0, 6'd7);

        // Contention: the read holds the load port off.
        @(posedge Clk_CI); #1;
        mem_if.LoadValid_SI = 1'b1;
        mem_if.LoadData_DI  = beat_word(1, 0, 0, 0);
        @(negedge Clk_CI);
        check("contend_load_ready", 64'(mem_if.LoadReady_SO), 64'd0);
        check("contend_valid", 64'(mem_if.Valid_SO), 64'd1);
        @(posedge Clk_CI); #1;
        @(negedge Clk_CI);
        check("contend_state", 64'(mem_if.State_DO), 64'(ST_SERVE));
        check("contend_ready", 64'(mem_if.Ready_SO), 64'd1);

        // Dropping the request lets the beat in and restarts the load.
        @(posedge Clk_CI); #1;
        mem_if.Req_SI = 1'b0;
        @(negedge Clk_CI);
        check("reload_load_ready", 64'(mem_if.LoadReady_SO), 64'd1);
        check("reload_valid_drop", 64'(mem_if.Valid_SO), 64'd0);
        @(posedge Clk_CI); #1;
        mem_if.LoadData_DI = beat_word(1, 0, 0, 1);
        @(negedge Clk_CI);
        check("reload_state", 64'(mem_if.State_DO), 64'(ST_LOAD));
        check("reload_ready_drop", 64'(mem_if.Ready_SO), 64'd0);
        check("reload_valid_low", 64'(mem_if.Valid_SO), 64'd0);

        // Continue into IM row 3, then reset mid-row.
        stream(1, 2, 3 * BEATS + 40 - 2);
        @(negedge Clk_CI);
        check("midload_state", 64'(mem_if.State_DO), 64'(ST_LOAD));
        @(posedge Clk_CI); #1;
        Reset_RBI = 1'b0;
        @(negedge Clk_CI);
        check_reset("rst_mid");
        @(posedge Clk_CI); #1;
        Reset_RBI = 1'b1;

        full_load(2, "load2");
        do_read(2, 6'd0);
        do_read(2, 6'd31);
        do_read(2, 6'd5);
        do_read(2, 6'd17);
        do_read(2, 6'd32);

        @(negedge Clk_CI);
        check("exp_q_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
